// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 64-bit RV64M divider.
package div_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [63:0] MIN_INT64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MIN_INT32 = 32'h8000_0000;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic [63:0] sext_w(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem, quot} left, subtract divisor if it fits.
module div_step
  import div_pkg::*;
(
  input  logic [63:0] rem_i,
  input  logic [63:0] quot_i,
  input  logic [63:0] divisor_i,
  output logic [63:0] rem_o,
  output logic [63:0] quot_o
);

  logic [64:0] shifted;
  logic [64:0] trial;
  logic        fits;

  always_comb begin
    shifted = {rem_i, quot_i[63]};
    trial   = shifted - {1'b0, divisor_i};
    // With the shifted-out bit set the value exceeds any 64-bit divisor;
    // otherwise trial[64] is the borrow of the 65-bit subtract.
    fits    = shifted[64] | ~trial[64];
    if (fits) begin
      rem_o  = trial[63:0];
      quot_o = {quot_i[62:0], 1'b1};
    end else begin
      rem_o  = shifted[63:0];
      quot_o = {quot_i[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_64bit_iter.sv
// Multi-cycle RV64M divider: fixed 64-step restoring loop with valid/ready on both sides.
// state | meaning: IDLE wait for request | CALC one step per cycle | FIX sign/select result | DONE hold result until accepted
module div_64bit_iter
  import div_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  op_i,
  input  logic        is_word_i,
  input  logic [63:0] dividend_i,
  input  logic [63:0] divisor_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] result_o
);

  div_state_t       state_q;
  div_op_t          op_q;
  logic             is_word_q;
  logic             quot_neg_q;
  logic             rem_neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      rem_q;
  logic [63:0]      quot_q;
  logic [63:0]      div_q;
  logic [63:0]      result_q;
  logic             out_valid_q;

  logic [63:0] rem_d;
  logic [63:0] quot_d;

  div_op_t     op_in;
  logic        in_signed;
  logic        in_is_rem;
  logic [63:0] a_ext, b_ext;
  logic        a_neg, b_neg;
  logic [63:0] a_abs, b_abs;
  logic        b_zero, ovf;
  logic [63:0] special_res;
  logic [63:0] q_fix, r_fix, sel_res, fix_res;

  div_step u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (div_q),
    .rem_o     (rem_d),
    .quot_o    (quot_d)
  );

  // Operand preparation and the single-cycle special cases at accept time.
  always_comb begin
    op_in     = div_op_t'(op_i);
    in_signed = (op_in == OP_DIV) || (op_in == OP_REM);
    in_is_rem = (op_in == OP_REM) || (op_in == OP_REMU);
    if (is_word_i) begin
      a_ext = in_signed ? sext_w(dividend_i) : {32'b0, dividend_i[31:0]};
      b_ext = in_signed ? sext_w(divisor_i)  : {32'b0, divisor_i[31:0]};
    end else begin
      a_ext = dividend_i;
      b_ext = divisor_i;
    end
    a_neg  = in_signed & a_ext[63];
    b_neg  = in_signed & b_ext[63];
    a_abs  = a_neg ? (64'd0 - a_ext) : a_ext;
    b_abs  = b_neg ? (64'd0 - b_ext) : b_ext;
    b_zero = (b_ext == 64'd0);
    ovf    = in_signed && (b_ext == '1) &&
             (a_ext == (is_word_i ? {{32{1'b1}}, MIN_INT32} : MIN_INT64));
    if (in_is_rem) special_res = b_zero ? a_ext : 64'd0;
    else           special_res = b_zero ? '1    : a_ext;
    if (is_word_i) special_res = sext_w(special_res);
  end

  always_comb begin
    q_fix   = quot_neg_q ? (64'd0 - quot_q) : quot_q;
    r_fix   = rem_neg_q  ? (64'd0 - rem_q)  : rem_q;
    sel_res = ((op_q == OP_REM) || (op_q == OP_REMU)) ? r_fix : q_fix;
    fix_res = is_word_q ? sext_w(sel_res) : sel_res;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_q        <= OP_DIV;
      is_word_q   <= 1'b0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      div_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            op_q       <= op_in;
            is_word_q  <= is_word_i;
            quot_neg_q <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            div_q      <= b_abs;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= a_abs;
            if (b_zero || ovf) begin
              result_q    <= special_res;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q     <= CALC;
            end
          end
        end
        CALC: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_q <= FIX;
        end
        FIX: begin
          result_q    <= fix_res;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_div_64bit_iter.sv
// Scoreboard bench for div_64bit_iter: expected results queued at accept, checked at out_valid.
module tb_div_64bit_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        is_word;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  always #5 clk = ~clk;

  div_64bit_iter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .is_word_i   (is_word),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result)
  );

  typedef struct {
    string       tag;
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // Reference model built on the simulator's own / and % operators.
  task automatic model(input logic [1:0] m_op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    logic        sgn;
    logic [63:0] x, y, q, r;
    sgn = ~m_op[0];
    x = w ? (sgn ? sx32(a) : {32'b0, a[31:0]}) : a;
    y = w ? (sgn ? sx32(b) : {32'b0, b[31:0]}) : b;
    lat = 66;
    if (y == 64'd0) begin
      q = '1; r = x; lat = 1;
    end else if (sgn && y == '1 &&
                 x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
      q = x; r = 64'd0; lat = 1;
    end else if (sgn) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    res = m_op[1] ? r : q;
    if (w) res = sx32(res);
  endtask

  task automatic send(input string tag, input logic [1:0] s_op, input logic w,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp_res, input int exp_lat);
    exp_t e;
    @(negedge clk);
    check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
    op = s_op; is_word = w; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    e.tag = tag; e.res = exp_res; e.lat = exp_lat;
    sb.push_back(e);
  endtask

  task automatic collect(input int hold);
    int   lat;
    exp_t e;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    if (sb.size() == 0) begin
      check_eq("scoreboard empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check_eq({e.tag, " result"}, result, e.res);
    check_eq({e.tag, " latency"}, 64'(lat), 64'(e.lat));
    check_eq({e.tag, " in_ready in DONE"}, 64'(in_ready), 64'd0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_eq({e.tag, " bp out_valid"}, 64'(out_valid), 64'd1);
      check_eq({e.tag, " bp result"}, result, e.res);
      check_eq({e.tag, " bp in_ready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_eq({e.tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    check_eq({e.tag, " in_ready back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] r_op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input int hold);
    send(tag, r_op, w, a, b, exp_res, exp_lat);
    collect(hold);
  endtask

  task automatic run_model(input string tag, input logic [1:0] r_op, input logic w,
                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] res;
    int          lat;
    model(r_op, w, a, b, res, lat);
    run_op(tag, r_op, w, a, b, res, lat, 0);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check_eq(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = DIV; is_word = 1'b0;
    dividend = '0; divisor = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset in_ready", 64'(in_ready), 64'd1);
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset result", result, 64'd0);

    run_op("DIVU 100/7", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, 0);
    run_op("REMU 100/7", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66, 0);
    run_op("DIV -100/7", DIV, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66, 0);
    run_op("REM -100/7", REM, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    run_op("REM 100/-7", REM, 1'b0, 64'd100, -64'sd7, 64'd2, 66, 0);
    run_op("DIV x/0", DIV, 1'b0, 64'd12345, 64'd0, '1, 1, 0);
    run_op("REMU 0x1234/0", REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, 0);
    run_op("DIV min/-1", DIV, 1'b0, 64'h8000_0000_0000_0000, '1,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("REM min/-1", REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("DIVW ovf", DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("DIVUW ffffffff/2", DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2,
           64'h0000_0000_7FFF_FFFF, 66, 0);
    run_op("REMW 7/0", REM, 1'b1, 64'd7, 64'd0, 64'd7, 1, 0);
    run_op("DIVU min/1", DIVU, 1'b0, 64'h8000_0000_0000_0000, 64'd1,
           64'h8000_0000_0000_0000, 66, 0);
    run_op("DIVU backpressure", DIVU, 1'b0, 64'd1000, 64'd9, 64'd111, 66, 10);

    // Flush mid-CALC: no output, back to IDLE immediately.
    @(negedge clk);
    op = DIVU; is_word = 1'b0; dividend = 64'd1000; divisor = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_eq("flush out_valid", 64'(out_valid), 64'd0);
    check_eq("flush in_ready", 64'(in_ready), 64'd1);
    watch_quiet("flush no output", 80);

    // Flush together with in_valid in IDLE must not accept.
    @(negedge clk);
    op = DIV; dividend = 64'd5; divisor = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    check_eq("flush+valid in_ready", 64'(in_ready), 64'd1);
    check_eq("flush+valid out_valid", 64'(out_valid), 64'd0);
    watch_quiet("flush+valid no output", 5);
    run_op("DIV after flush", DIV, 1'b0, 64'd77, -64'sd5, -64'sd15, 66, 0);

    // Reset in the middle of CALC.
    @(negedge clk);
    op = DIVU; is_word = 1'b0; dividend = 64'd999; divisor = 64'd10; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("midcalc rst in_ready", 64'(in_ready), 64'd1);
    check_eq("midcalc rst out_valid", 64'(out_valid), 64'd0);
    check_eq("midcalc rst result", result, 64'd0);
    watch_quiet("midcalc rst no output", 80);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  r_op;
      logic        r_w;
      logic [63:0] r_a, r_b;
      r_op = 2'($urandom_range(0, 3));
      r_w  = 1'($urandom_range(0, 1));
      r_a  = {$urandom, $urandom};
      r_b  = (i % 2 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      if (i % 2 == 0 && r_op[0] == 1'b0 && (i % 4 == 0)) r_b = 64'd0 - r_b;
      run_model($sformatf("rand%0d", i), r_op, r_w, r_a, r_b);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_64bit_iter.md
Name: div_64bit_iter

Overview:
- Multi-cycle 64-bit integer divider for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW operations.
- Sits beside the ALU as the inverse of its adder path: one restoring radix-2 subtract step per cycle.
- Valid/ready handshakes on the input and output sides, so the execute stage can stall on it.
- A flush input lets the pipeline kill an in-flight operation.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 7, iteration counter width (log2(XLEN)+1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  high only in IDLE.
- op  input  2  div_op_t: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- is_word  input  1  selects the W variant (32-bit operands, sign-extended result).
- dividend  input  64  rs1.
- divisor  input  64  rs2.
- flush  input  1  abort the current operation and return to IDLE.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- result  output  64  quotient or remainder, selected by op.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, counter=0. All internal registers clear.
- Accept: a request is accepted on a rising edge with in_valid && in_ready. op, is_word and the operands are latched.
- Operand prep (at accept):
  - is_word=1: operands are bits [31:0], sign-extended for DIV/REM, zero-extended for DIVU/REMU.
  - Signed ops: the magnitude of each operand is taken. quot_neg = sign(a) XOR sign(b). rem_neg = sign(a).
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - Accept with divisor (after W masking) == 0: go straight to DONE. Quotient = all ones; remainder = latched dividend (W: sign-extended low 32).
  - Accept with signed overflow (dividend = most-negative value, divisor = -1, at 64 or 32 bits per is_word): go to DONE. Quotient = dividend; remainder = 0.
  - Otherwise: go to CALC with counter=0, partial remainder=0, quotient register = |dividend|.
- CALC (one restoring step per cycle):
  - Shift {rem, quot} left by 1.
  - Compute trial = rem_shifted - |divisor| at 65 bits.
  - trial non-negative: rem = trial, quot LSB = 1. Negative: rem unchanged, quot LSB = 0.
  - Counter increments; after the 64th step (counter==63) go to FIX.
  - W ops still run 64 steps; latency is fixed.
- FIX:
  - Apply negation: quotient if quot_neg, remainder if rem_neg (signed ops only).
  - Select the result by op. If is_word, sign-extend from bit 31. Register the result and go to DONE.
- DONE:
  - out_valid=1 and result stable. On out_ready, go to IDLE the next cycle.
  - Back-to-back: in_ready is 0 while in DONE, so a new request is accepted no earlier than the cycle after the handshake.
- Latency from the accept edge to the first out_valid cycle:
  - Normal ops: 66 cycles (64 CALC + 1 FIX + DONE entry).
  - Divide-by-zero and overflow: 1 cycle.
- flush: in any state, the next state is IDLE, out_valid=0, and the result is discarded. flush beats out_ready and in_valid in the same cycle. In IDLE, flush with in_valid does not accept.
- rst has priority over flush; reset mid-CALC returns to IDLE with no output.
- Invariants:
  - result changes only on entry to DONE.
  - out_valid never deasserts without out_ready, except on flush or rst.

Decomposition:
- Package div_pkg holds:
  - typedef enum div_op_t (DIV, DIVU, REM, REMU).
  - typedef enum div_state_t (IDLE, CALC, FIX, DONE).
  - Constants XLEN=64 and MIN_INT64/MIN_INT32.
- Sub-module div_step is natural: combinational, one restoring iteration.
  - Inputs: 64-bit rem, 64-bit quot, 64-bit divisor.
  - Outputs: next rem, next quot.
  - Uses a 65-bit subtract.

Test Plan:
- DIVU 100/7, then REMU 100/7 -> result 14, then 2; out_valid exactly 66 cycles after each accept.
- DIV -100/7 -> 0xFFFF_FFFF_FFFF_FFF2 (-14). REM -100/7 -> -2. REM 100/-7 -> 2.
- DIV x/0 -> all ones, REMU 0x1234/0 -> 0x1234, each 1 cycle after accept. DIV 0x8000_0000_0000_0000/-1 -> same value; REM of the same operands -> 0.
- DIVW 0xFFFF_FFFF_8000_0000 / 0x0000_0000_FFFF_FFFF -> 0xFFFF_FFFF_8000_0000. DIVUW 0xFFFF_FFFF/2 -> 0x0000_0000_7FFF_FFFF. REMW 7/0 -> 7.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> result and out_valid stable, in_ready=0. Release -> in_ready=1 the next cycle.
- flush at CALC cycle 30 -> IDLE next cycle, no out_valid. A new request then accepts and produces a correct result. rst asserted mid-CALC -> all outputs at reset values.
